// File: rtl/dtack_wait_controller.sv
// DTACK / wait-state controller for a 68k-style bus. An address-strobe cycle
// is steered to one decoder channel, which either counts a fixed number of
// wait states or waits on the device's own dtack with a bus-error timeout.
// Sticky status records timeouts and overlapping decoder selects.
module dtack_wait_controller #(
  parameter int NUM_CH  = 4,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_h_i,
  input  logic                       as_l_i,
  input  logic [NUM_CH-1:0]          select_h_i,
  input  logic [NUM_CH-1:0]          ext_mode_h_i,
  input  logic [NUM_CH-1:0]          ext_dtack_l_i,
  input  logic [NUM_CH*WAIT_W-1:0]   wait_count_i,
  input  logic                       clear_status_h_i,
  output logic                       dtack_out_l_o,
  output logic                       berr_l_o,
  output logic                       timeout_flag_h_o,
  output logic [2:0]                 timeout_ch_o,
  output logic                       multi_sel_flag_h_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_EXT  = 3'd2,
    S_ACK  = 3'd3,
    S_BERR = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;      // AS_L seen high since the last cycle start
  logic [2:0]          ch_q, ch_d;            // channel latched at cycle start
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]         to_cnt_q, to_cnt_d;
  logic                dtack_q, dtack_d;
  logic                berr_q, berr_d;
  logic                to_flag_q, to_flag_d;
  logic [2:0]          to_ch_q, to_ch_d;
  logic                ms_flag_q, ms_flag_d;

  logic                sel_any;
  logic [2:0]          sel_idx;
  logic                sel_ext;
  logic [WAIT_W-1:0]   sel_wait;
  logic                ext_dtack_sel;
  logic                to_set;
  logic                ms_set;

  // Priority-decode the selects: scanning downward lets the lowest set bit win.
  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = 3'd0;
    sel_ext  = 1'b0;
    sel_wait = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (select_h_i[i]) begin
        sel_any  = 1'b1;
        sel_idx  = 3'(i);
        sel_ext  = ext_mode_h_i[i];
        sel_wait = wait_count_i[i*WAIT_W +: WAIT_W];
      end
    end
  end

  // Pick the device dtack of the channel latched for the current cycle.
  always_comb begin
    ext_dtack_sel = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 3'(i)) begin
        ext_dtack_sel = ext_dtack_l_i[i];
      end
    end
  end

  // Next-state, counter and status logic; outputs are derived from the next state.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | as_l_i;
    ch_d       = ch_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    to_ch_d    = to_ch_q;
    to_set     = 1'b0;
    ms_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!as_l_i && armed_q) begin
          armed_d = 1'b0;
          ch_d    = sel_idx;
          ms_set  = ($countones(select_h_i) > 1);
          if (!sel_any) begin
            state_d = S_ACK;
          end else if (sel_ext) begin
            state_d  = S_EXT;
            to_cnt_d = '0;
          end else if (sel_wait == '0) begin
            state_d = S_ACK;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = sel_wait;
          end
        end
      end
      S_WAIT: begin
        if (as_l_i) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_W'(1)) begin
          state_d    = S_ACK;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_EXT: begin
        // Device dtack is checked before the timeout so a late dtack still wins.
        if (as_l_i) begin
          state_d = S_IDLE;
        end else if (!ext_dtack_sel) begin
          state_d = S_ACK;
        end else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = S_BERR;
          to_set  = 1'b1;
          to_ch_d = ch_q;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_ACK, S_BERR: begin
        if (as_l_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dtack_d   = (state_d != S_ACK);
    berr_d    = (state_d != S_BERR);
    to_flag_d = to_set | (to_flag_q & ~clear_status_h_i);
    ms_flag_d = ms_set | (ms_flag_q & ~clear_status_h_i);
  end

  // State, counters, latches and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_h_i) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b0;
      ch_q       <= 3'd0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      to_flag_q  <= 1'b0;
      to_ch_q    <= 3'd0;
      ms_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      ch_q       <= ch_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      to_flag_q  <= to_flag_d;
      to_ch_q    <= to_ch_d;
      ms_flag_q  <= ms_flag_d;
    end
  end

  assign dtack_out_l_o      = dtack_q;
  assign berr_l_o           = berr_q;
  assign timeout_flag_h_o   = to_flag_q;
  assign timeout_ch_o       = to_ch_q;
  assign multi_sel_flag_h_o = ms_flag_q;

endmodule

// File: doc/dtack_wait_controller.md
DTACK_WAIT_CONTROLLER -- requirements
Module: dtack_wait_controller

Interface
REQ-001 Parameter NUM_CH, default 4, range 1..8: number of decoder select/dtack channels.
REQ-002 Parameter WAIT_W, default 4: width of each per-channel wait-state count.
REQ-003 Parameter TIMEOUT, default 255, range 2..65535: cycle limit for external-dtack channels before bus error.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset_H  in  1  synchronous, active-high reset.
REQ-006 AS_L  in  1  CPU address strobe, synchronous to Clk, active low.
REQ-007 Select_H  in  NUM_CH  address-decoder selects, active high.
REQ-008 ExtMode_H  in  NUM_CH  per channel: 1 = dtack from ExtDtack_L, 0 = internally counted wait states.
REQ-009 ExtDtack_L  in  NUM_CH  per-channel device dtack, active low.
REQ-010 WaitCount  in  NUM_CH*WAIT_W  wait states per channel; channel i occupies bits [i*WAIT_W +: WAIT_W].
REQ-011 ClearStatus_H  in  1  clears the sticky timeout status.
REQ-012 DtackOut_L  out  1  registered dtack to CPU.
REQ-013 BErr_L  out  1  registered bus error to CPU.
REQ-014 TimeoutFlag_H  out  1  sticky: a timeout has occurred.
REQ-015 TimeoutCh  out  3  index of the channel that caused the most recent timeout.
REQ-016 MultiSelFlag_H  out  1  sticky: more than one Select_H bit was high at a cycle start.

Function
REQ-017 FSM states: IDLE, WAIT, EXT, ACK, BERR; all outputs registered.
REQ-018 IDLE: DtackOut_L=1, BErr_L=1; a cycle starts at the first edge N where AS_L is sampled 0.
REQ-019 At edge N, latch the channel index, mode and WaitCount; later changes to Select_H, ExtMode_H or WaitCount are ignored until the next IDLE.
REQ-020 Multiple selects: the lowest-index set bit wins; MultiSelFlag_H is set at edge N.
REQ-021 No select at N: go to ACK; DtackOut_L goes low at edge N (zero wait states, default fast path).
REQ-022 Internal mode, W = latched WaitCount: W=0 means ACK at edge N; W>0 means WAIT with counter=W, decrement each edge, ACK when counter reaches 0. DtackOut_L falls at edge N+W.
REQ-023 WaitCount is treated as unsigned; the maximum 2^WAIT_W-1 is valid.
REQ-024 External mode: go to EXT at N and clear the timeout counter. At each edge, if the latched ExtDtack_L is sampled 0, go to ACK (DtackOut_L low that edge); otherwise increment the counter.
REQ-025 EXT timeout: when TIMEOUT edges have passed since N without dtack, go to BERR on edge N+TIMEOUT. BErr_L=0, DtackOut_L stays 1, TimeoutFlag_H is set and TimeoutCh is loaded.
REQ-026 Dtack and timeout on the same edge: dtack wins, go to ACK.
REQ-027 ACK and BERR hold their outputs until AS_L is sampled 1, then go to IDLE; DtackOut_L and BErr_L return to 1 on that edge.
REQ-028 AS_L sampled 1 in WAIT or EXT (aborted cycle): go to IDLE with no dtack, no bus error and no status change.
REQ-029 A new cycle needs AS_L sampled 1 in IDLE first; AS_L held low after ACK/BERR never restarts a cycle.
REQ-030 DtackOut_L and BErr_L are never 0 at the same time.
REQ-031 ClearStatus_H clears TimeoutFlag_H and MultiSelFlag_H. If a set event happens on the same edge, the set wins.

Reset
REQ-032 On an edge with Reset_H=1: state=IDLE, DtackOut_L=1, BErr_L=1, TimeoutFlag_H=0, TimeoutCh=0, MultiSelFlag_H=0, and all counters and latches cleared.
REQ-033 Reset mid-cycle (any state) aborts the cycle with no dtack; the next cycle needs AS_L to go high, then low again.

Verification
REQ-034 NUM_CH=4. AS_L low with no select -> DtackOut_L low on that same edge N; AS_L high -> DtackOut_L high on the next edge.
REQ-035 Channel 2 internal, WaitCount=5 -> DtackOut_L falls at N+5. WaitCount=15 -> falls at N+15. WaitCount=0 -> falls at N.
REQ-036 Channel 1 external, ExtDtack_L low at N+7 -> DtackOut_L low at N+7. ExtDtack_L never low, TIMEOUT=20 -> BErr_L low at N+20, TimeoutFlag_H=1, TimeoutCh=1; ClearStatus_H pulse -> flag 0.
REQ-037 Select_H=4'b1010 -> channel 1 is used and MultiSelFlag_H=1. AS_L released at N+3 during WaitCount=8 -> no dtack, IDLE.
REQ-038 Reset_H pulsed at N+2 of a WaitCount=6 cycle -> no dtack, all outputs at reset values; AS_L still low -> no new cycle until AS_L goes high, then low.
